// File: rtl/signed_mac_accumulator.sv
// Signed multiply-accumulate: one saturated dot product per vector.
// Two-stage datapath (product register, then accumulate) with an
// ACCUM / DRAIN / HOLD handshake controller.
// Optional build macro SIGNED_MAC_RELU_EN: negative results are zeroed in out_data.
//
// state | meaning
// ACCUM | accepting operand pairs, one per cycle
// DRAIN | last product still in S1; fold it and capture the result
// HOLD  | result presented, waiting for out_ready
module signed_mac_accumulator #(
  parameter int DATA_W  = 8,
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 16,
  parameter int MAX_LEN = 1024,
  parameter int CNT_W   = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_forced
);

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  state_t state, state_nxt;

  logic                     accept;
  logic                     force_last;
  logic                     out_take;
  logic signed [PROD_W-1:0] prod;

  logic                     s1_valid;
  logic                     s1_forced;
  logic signed [PROD_W-1:0] s1_prod;

  logic signed [ACC_W-1:0]  acc;
  logic                     acc_sat;
  logic [CNT_W-1:0]         cnt;

  logic [ACC_W:0]           acc_sum;
  logic [ACC_W-1:0]         acc_fold;
  logic                     acc_fold_sat;
  logic [OUT_W-1:0]         narrow;
  logic                     narrow_sat;

  assign accept     = in_valid && in_ready;
  assign force_last = (cnt == CNT_W'(MAX_LEN - 1));
  assign out_take   = (state == HOLD) && out_ready;
  assign prod       = $signed(in_a) * $signed(in_b);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && (in_last || force_last)) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Accumulate at ACC_W+1 bits, clamp to ACC_W, then narrow to OUT_W
  always_comb begin
    acc_sum      = {acc[ACC_W-1], acc} +
                   {{(ACC_W+1-PROD_W){s1_prod[PROD_W-1]}}, s1_prod};
    acc_fold     = acc;
    acc_fold_sat = 1'b0;
    if (s1_valid) begin
      if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
        acc_fold_sat = 1'b1;
        acc_fold     = acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_fold = acc_sum[ACC_W-1:0];
      end
    end
    narrow_sat = !((&acc_fold[ACC_W-1:OUT_W-1]) || !(|acc_fold[ACC_W-1:OUT_W-1]));
    if (narrow_sat)
      narrow = acc_fold[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                 : {1'b0, {(OUT_W-1){1'b1}}};
    else
      narrow = acc_fold[OUT_W-1:0];
`ifdef SIGNED_MAC_RELU_EN
    if (narrow[OUT_W-1]) narrow = '0;
`endif
  end

  // S1: product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_forced <= 1'b0;
      s1_prod   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_prod   <= prod;
        s1_forced <= force_last;
      end
    end
  end

  // S2: accumulator, sticky saturation and term counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      acc_sat <= 1'b0;
      cnt     <= '0;
    end else if (out_take) begin
      acc     <= '0;
      acc_sat <= 1'b0;
      cnt     <= '0;
    end else begin
      acc     <= acc_fold;
      acc_sat <= acc_sat | acc_fold_sat;
      if (accept) cnt <= cnt + 1'b1;
    end
  end

  // Result capture on the DRAIN edge, held stable through HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_sat    <= 1'b0;
      out_count  <= '0;
      out_forced <= 1'b0;
    end else if (state == DRAIN) begin
      out_data   <= narrow;
      out_sat    <= acc_sat | acc_fold_sat | narrow_sat;
      out_count  <= cnt;
      out_forced <= s1_forced;
    end
  end

endmodule

// File: tb/tb_signed_mac_accumulator.sv
// Bench for signed_mac_accumulator: directed cases plus random vectors,
// checked against a plain-arithmetic dot-product model.
module tb_signed_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_sat;
  logic [10:0] out_count;
  logic        out_forced;

  int errors = 0;
  int checks = 0;
  int va [0:1023];
  int vb [0:1023];

  signed_mac_accumulator dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat),
    .out_count(out_count), .out_forced(out_forced)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: running sum clamped to 24-bit range per term, then clamped to 16 bits.
  task automatic model(input int n, output longint d, output int sat);
    longint acc = 0;
    sat = 0;
    for (int i = 0; i < n; i++) begin
      acc = acc + longint'(va[i]) * longint'(vb[i]);
      if (acc > 8388607) begin acc = 8388607; sat = 1; end
      else if (acc < -8388608) begin acc = -8388608; sat = 1; end
    end
    d = acc;
    if (d > 32767) begin d = 32767; sat = 1; end
    else if (d < -32768) begin d = -32768; sat = 1; end
`ifdef SIGNED_MAC_RELU_EN
    if (d < 0) d = 0;
`endif
  endtask

  task automatic run_vector(input int n, input bit use_last, input int hold, input bit rnd_ready);
    longint exp_d;
    int exp_s;
    int waits;
    model(n, exp_d, exp_s);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("in_ready_accum", in_ready, 1);
      in_valid  = 1'b1;
      in_a      = 8'(va[i]);
      in_b      = 8'(vb[i]);
      in_last   = use_last && (i == n - 1);
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 0);
    @(negedge clk);
    waits = 1;
    while (!out_valid && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    check("latency", waits, 1);
    check("out_data", longint'($signed(out_data)), exp_d);
    check("out_sat", out_sat, exp_s);
    check("out_count", out_count, n);
    check("out_forced", out_forced, (n == 1024) ? 1 : 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_data", longint'($signed(out_data)), exp_d);
      check("hold_count", out_count, n);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;

    va[0] = -5; vb[0] = 10;
    run_vector(1, 1, 0, 0);

    va[0] = 20; vb[0] = 15; va[1] = -5; vb[1] = 10; va[2] = 3; vb[2] = -4;
    run_vector(3, 1, 1, 1);

    for (int i = 0; i < 4; i++) begin va[i] = -128; vb[i] = -128; end
    run_vector(4, 1, 0, 0);

    for (int i = 0; i < 1024; i++) begin va[i] = -128; vb[i] = 127; end
    run_vector(1024, 0, 0, 0);

    va[0] = 7; vb[0] = 9; va[1] = -3; vb[1] = 4;
    run_vector(2, 1, 5, 0);
    va[0] = -128; vb[0] = -1;
    run_vector(1, 1, 0, 0);

    // Reset in the middle of a vector
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 8'd100; in_b = 8'd100; in_last = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_sat", out_sat, 0);
    check("midrst_out_count", out_count, 0);
    check("midrst_out_forced", out_forced, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    va[0] = 2; vb[0] = 3;
    run_vector(1, 1, 0, 0);

    for (int t = 0; t < 12; t++) begin
      n = int'($urandom_range(1, 24));
      for (int i = 0; i < n; i++) begin
        if (t % 4 == 3) begin
          va[i] = ($urandom_range(0, 1) != 0) ? -128 : 127;
          vb[i] = ($urandom_range(0, 1) != 0) ? -128 : 127;
        end else begin
          va[i] = int'($signed(8'($urandom_range(0, 255))));
          vb[i] = int'($signed(8'($urandom_range(0, 255))));
        end
      end
      run_vector(n, 1, int'($urandom_range(0, 3)), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
